fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the instruction fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] INST_NONE = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, imem request/response and decoder stream bundle
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            imem_resp_error;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_fault;

  modport master (
    input  redirect, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_error,
    output out_valid, out_inst, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_error,
    input  out_valid, out_inst, out_pc, out_fault,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry synchronous FIFO with flush, entry 0 is always the head
module fetch_queue #(
  parameter int WIDTH = 65
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop && (count_q != 2'd0)) begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      // count_d already reflects this cycle's pop, so a push into a full queue with a pop lands in entry 1
      if (push && (count_d != 2'd2)) begin
        if (count_d == 2'd0) ent0_d = push_data;
        else                 ent1_d = push_data;
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_data = ent0_q;
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with redirect drop accounting and fault halt
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int QW = 32 + XLEN + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [1:0]      outstanding_q, outstanding_d;
  logic [1:0]      drop_q, drop_d;
  logic            pend_fault_q, pend_fault_d;

  logic [1:0]      q_count;
  logic [QW-1:0]   q_head, q_push_data;
  logic            q_push, q_pop;
  logic            req_fire, resp_take, resp_live, misaligned;
  logic [1:0]      outstanding_acc;

  assign bus.imem_req_valid = !reset && (state_q == ST_RUN) && !bus.redirect &&
                              (({1'b0, q_count} + {1'b0, outstanding_q}) < 3'd2);
  assign bus.imem_req_addr  = fetch_pc_q;

  assign bus.out_valid = (q_count != 2'd0);
  assign bus.out_inst  = bus.out_valid ? q_head[QW-1 -: 32] : INST_NONE;
  assign bus.out_pc    = bus.out_valid ? q_head[XLEN:1] : '0;
  assign bus.out_fault = bus.out_valid && q_head[0];
  assign q_pop         = bus.out_valid && bus.out_ready;

  always_comb begin
    misaligned      = (bus.redirect_pc[1:0] != 2'b00);
    req_fire        = bus.imem_req_valid && bus.imem_req_ready;
    resp_take       = bus.imem_resp_valid && (outstanding_q != 2'd0);
    resp_live       = resp_take && (drop_q == 2'd0) && !bus.redirect;
    outstanding_acc = outstanding_q - {1'b0, resp_take};
    outstanding_d   = outstanding_acc + {1'b0, req_fire};

    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    drop_d       = drop_q;
    state_d      = state_q;
    pend_fault_d = pend_fault_q;
    q_push       = 1'b0;
    q_push_data  = '0;

    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);

    if (bus.redirect) begin
      // Everything still in flight belongs to the old stream, including a response arriving now
      drop_d       = outstanding_acc;
      fetch_pc_d   = bus.redirect_pc;
      resp_pc_d    = bus.redirect_pc;
      state_d      = misaligned ? ST_HALT : ST_RUN;
      pend_fault_d = misaligned;
    end else if (pend_fault_q && (drop_q == 2'd0)) begin
      q_push       = 1'b1;
      q_push_data  = {INST_NONE, resp_pc_q, 1'b1};
      pend_fault_d = 1'b0;
      state_d      = ST_HALT;
    end else begin
      if (resp_take && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
      if (resp_live) begin
        q_push      = 1'b1;
        q_push_data = {bus.imem_resp_error ? INST_NONE : bus.imem_resp_data,
                       resp_pc_q, bus.imem_resp_error};
        resp_pc_d   = resp_pc_q + XLEN'(PC_STEP);
        if (bus.imem_resp_error) state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      pend_fault_q  <= 1'b0;
    end else begin
      assert (!(bus.imem_resp_valid && (outstanding_q == 2'd0)));
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      pend_fault_q  <= pend_fault_d;
    end
  end

  fetch_queue #(.WIDTH(QW)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a stream-level model
module tb_fetch_unit;

  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } mreq_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic        c_reset, c_redirect, c_req_ready, c_out_ready;
  logic [31:0] c_rpc;
  int          resp_prob;

  mreq_t       mem_q[$];
  int          epoch = 0;
  logic [31:0] exp_req, exp_out, mis_pc, err_addr;
  bit          halted, mis_epoch, rand_err, fault_seen;
  int          out_cnt, live_cnt, n_req;

  logic        s_req_valid, s_out_valid, s_out_fault, s_resp_valid;
  logic [31:0] s_req_addr, s_out_inst, s_out_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && (a[7:2] == 6'h15));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    mreq_t r;
    bit    e;
    @(negedge clock);
    reset              = c_reset;
    bus.redirect       = c_redirect;
    bus.redirect_pc    = c_rpc;
    bus.imem_req_ready = c_req_ready;
    bus.out_ready      = c_out_ready;
    if (!c_reset && (mem_q.size() > 0) && ($urandom_range(99) < resp_prob)) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_error = mem_err(mem_q[0].addr);
      bus.imem_resp_data  = bus.imem_resp_error ? $urandom : mem_data(mem_q[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_error = 1'($urandom_range(1));
      bus.imem_resp_data  = $urandom;
    end
    #1;
    s_req_valid  = bus.imem_req_valid;
    s_req_addr   = bus.imem_req_addr;
    s_out_valid  = bus.out_valid;
    s_out_inst   = bus.out_inst;
    s_out_pc     = bus.out_pc;
    s_out_fault  = bus.out_fault;
    s_resp_valid = bus.imem_resp_valid;

    if (c_reset) begin
      mem_q.delete();
      epoch++;
      exp_req = RST_PC; exp_out = RST_PC;
      halted = 0; mis_epoch = 0; fault_seen = 0;
      out_cnt = 0; live_cnt = 0;
      return;
    end

    if (c_redirect || halted) check("no_req", s_req_valid, 1'b0);
    if (s_req_valid && c_req_ready) begin
      check("req_addr", s_req_addr, exp_req);
      mem_q.push_back('{s_req_addr, epoch});
      exp_req += 32'd4;
      n_req++;
    end

    if (s_out_valid && c_out_ready) begin
      out_cnt++;
      if (s_out_fault) fault_seen = 1;
      if (mis_epoch) begin
        check("mis_count", out_cnt, 1);
        check("mis_pc", s_out_pc, mis_pc);
        check("mis_inst", s_out_inst, 32'h0);
        check("mis_fault", s_out_fault, 1'b1);
      end else begin
        e = mem_err(exp_out);
        check("out_pc", s_out_pc, exp_out);
        check("out_inst", s_out_inst, e ? 32'h0 : mem_data(exp_out));
        check("out_fault", s_out_fault, e);
        exp_out += 32'd4;
      end
    end

    if (s_resp_valid) begin
      r = mem_q.pop_front();
      if ((r.epoch == epoch) && !c_redirect) begin
        live_cnt++;
        if (mem_err(r.addr)) halted = 1;
      end
    end

    if (c_redirect) begin
      epoch++;
      exp_req = c_rpc; exp_out = c_rpc;
      mis_epoch = (c_rpc[1:0] != 2'b00);
      halted = mis_epoch;
      mis_pc = c_rpc;
      out_cnt = 0; live_cnt = 0;
    end
  endtask

  task automatic drain_check(input string tag);
    c_redirect = 0; c_req_ready = 0; c_out_ready = 1; resp_prob = 100;
    repeat (12) step();
    check({tag, "_drained"}, s_out_valid, 1'b0);
    check({tag, "_count"}, out_cnt, live_cnt + (mis_epoch ? 1 : 0));
  endtask

  task automatic do_reset();
    c_reset = 1; c_redirect = 0;
    step();
    c_reset = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.redirect = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0; bus.out_ready = 0;
    bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.imem_resp_error = 0;
    c_reset = 1; c_redirect = 0; c_rpc = '0; c_req_ready = 1; c_out_ready = 1;
    resp_prob = 0; err_addr = 32'hFFFF_FFFC; rand_err = 0; n_req = 0;

    // Reset state
    step(); step();
    check("rst_req_valid", s_req_valid, 1'b0);
    check("rst_out_valid", s_out_valid, 1'b0);
    check("rst_out_inst", s_out_inst, 32'h0);
    check("rst_out_pc", s_out_pc, 32'h0);
    check("rst_out_fault", s_out_fault, 1'b0);

    // Streaming from reset with a single-cycle memory
    c_reset = 0; resp_prob = 100;
    step();
    check("first_req_valid", s_req_valid, 1'b1);
    check("first_req_addr", s_req_addr, RST_PC);
    check("first_out_valid", s_out_valid, 1'b0);
    step();
    check("second_req_addr", s_req_addr, RST_PC + 32'd4);
    check("no_bypass", s_out_valid, 1'b0);
    step();
    check("first_out_valid2", s_out_valid, 1'b1);
    repeat (20) step();
    drain_check("stream");

    // Decoder stall fills the queue
    do_reset();
    c_req_ready = 1; c_out_ready = 0; resp_prob = 100; n_req = 0;
    repeat (10) step();
    check("stall_reqs", n_req, 2);
    check("stall_out_valid", s_out_valid, 1'b1);
    check("stall_req_valid", s_req_valid, 1'b0);
    c_out_ready = 1;
    step();
    check("release_pc0", s_out_pc, RST_PC);
    step();
    check("release_pc1", s_out_pc, RST_PC + 32'd4);
    check("resume_reqs", n_req, 3);
    drain_check("stall");

    // Redirect with two requests in flight
    do_reset();
    c_req_ready = 1; c_out_ready = 1; resp_prob = 0;
    step(); step(); step();
    check("two_outstanding", s_req_valid, 1'b0);
    c_redirect = 1; c_rpc = 32'h0000_0100; resp_prob = 100;
    step();
    c_redirect = 0; c_req_ready = 1;
    step();
    check("redir_req_valid", s_req_valid, 1'b1);
    check("redir_req_addr", s_req_addr, 32'h0000_0100);
    repeat (10) step();
    drain_check("redir");

    // Error response halts fetch until redirect
    do_reset();
    err_addr = RST_PC + 32'd4;
    c_req_ready = 1; c_out_ready = 1; resp_prob = 100;
    repeat (15) step();
    check("err_fault_seen", fault_seen, 1'b1);
    check("err_halt_req", s_req_valid, 1'b0);
    c_redirect = 1; c_rpc = RST_PC;
    step();
    c_redirect = 0;
    step();
    check("err_restart_valid", s_req_valid, 1'b1);
    check("err_restart_addr", s_req_addr, RST_PC);
    drain_check("err");

    // Misaligned redirect
    c_redirect = 1; c_rpc = 32'h0000_0102; c_req_ready = 1;
    step();
    c_redirect = 0;
    repeat (8) step();
    check("mis_req_valid", s_req_valid, 1'b0);
    check("mis_entries", out_cnt, 1);
    drain_check("mis");

    // Redirect coinciding with a response and an output handshake
    do_reset();
    err_addr = 32'hFFFF_FFFC;
    c_req_ready = 1; c_out_ready = 0; resp_prob = 0;
    step(); step(); step();
    resp_prob = 100;
    step();
    c_redirect = 1; c_rpc = 32'h0000_0200; c_out_ready = 1;
    step();
    check("coinc_out_valid", s_out_valid, 1'b1);
    check("coinc_out_pc", s_out_pc, RST_PC);
    check("coinc_resp", s_resp_valid, 1'b1);
    c_redirect = 0; resp_prob = 0;
    step();
    check("coinc_empty", s_out_valid, 1'b0);
    check("coinc_req_valid", s_req_valid, 1'b1);
    check("coinc_req_addr", s_req_addr, 32'h0000_0200);
    drain_check("coinc");

    // Randomized traffic with redirects, misaligned targets and memory errors
    rand_err = 1;
    for (int i = 0; i < 1500; i++) begin
      c_req_ready = ($urandom_range(3) != 0);
      c_out_ready = ($urandom_range(3) != 0);
      resp_prob   = 60;
      c_redirect  = ($urandom_range(39) == 0);
      c_rpc       = 32'($urandom_range(1023)) << 2;
      if ($urandom_range(4) == 0) c_rpc[1:0] = 2'($urandom_range(3, 1));
      step();
      c_redirect = 0;
      if ((i % 300) == 299) drain_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
